video_scanner: RTL and testbench
================================

# video_scanner

Frame readout engine on the consuming side of the per-core `video` outputs. It snapshots the whole W×H `video` grid in one cycle on request, then streams the frozen frame out in raster order over a valid/ready pixel interface toward the display/host path. The cores keep running while the frame drains.

## Interface
Parameters:
- `W`, default 8: grid width in cores (X dimension), ≥1.
- `H`, default 8: grid height in cores (Y dimension), ≥1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous and active-high.
- `video_in`  in  `value_t` × W*H  per-core `video` values; element index `y*W + x`.
- `frame_req`  in  1  level request to capture and stream one frame.
- `pixel_ready`  in  1  downstream accepts the current pixel.
- `pixel_valid`  out  1  a pixel is presented.
- `pixel_data`  out  `value_t`  snapshot value at (`pixel_x`, `pixel_y`).
- `pixel_x`  out  $clog2(W) (min 1)  column of the current pixel.
- `pixel_y`  out  $clog2(H) (min 1)  row of the current pixel.
- `pixel_sof`  out  1  first pixel of frame (x=0, y=0).
- `pixel_eol`  out  1  last pixel of a row (x=W-1).
- `pixel_last`  out  1  last pixel of frame (x=W-1, y=H-1).
- `busy`  out  1  frame being streamed.
- `frame_dropped`  out  1  one-cycle pulse: `frame_req` sampled high while streaming.

## Operation
- States: IDLE, STREAM.
- IDLE: `pixel_valid`=0 and `busy`=0. On a clock edge with `frame_req`=1:
  - all W*H `video_in` values load into the snapshot buffer;
  - x and y clear to 0;
  - the block moves to STREAM.
- STREAM:
  - `pixel_valid`=1, `busy`=1, `pixel_data` = snapshot[y*W+x].
  - Flags are pure decodes of x and y.
  - On an edge with `pixel_valid && pixel_ready`:
    - if x<W-1: x increments;
    - else x clears to 0 and y increments;
    - if that pixel had `pixel_last`=1, the block returns to IDLE and x and y clear.
  - With `pixel_ready`=0, every output holds stable (AXI-stream rule). `pixel_valid` never drops mid-frame.
- `frame_req`=1 sampled in STREAM:
  - ignored (no recapture);
  - `frame_dropped` pulses the cycle after.
  - This applies even on the final handshake edge: that edge returns to IDLE, and a still-high `frame_req` is captured on the following edge.
- The snapshot is never modified during STREAM. `video_in` changes there have no effect.
- W=1 or H=1: flags overlap. W=H=1 gives one pixel with `sof`, `eol` and `last` all 1.
- Counter widths come from $clog2 with a minimum of 1 bit. Counters never reach W or H.

## Timing
- Reset values:
  - `pixel_valid`, `busy`, `frame_dropped` = 0;
  - x = y = 0, so `pixel_x` = `pixel_y` = 0;
  - `pixel_sof`=1 as a decode, but it is qualified by `pixel_valid`=0;
  - `pixel_data`=0, and the snapshot buffer is cleared to 0;
  - state = IDLE.
- Capture latency: `frame_req` high at edge N (in IDLE). The first pixel is valid in the cycle after edge N, and the data equals `video_in` as sampled at edge N.
- Throughput: one pixel per cycle while `pixel_ready`=1. A frame occupies exactly W*H cycles of STREAM.
- Back-to-back frames with `frame_req` held high: one IDLE bubble cycle between frames. Minimum frame period is W*H+1 cycles.
- Reset mid-frame: on the edge where `rst`=1, the block aborts. `pixel_valid`=0 from the next cycle, and no partial-frame completion occurs.
- All outputs are registered or decoded from registers. There is no combinational path from `pixel_ready` or `frame_req` to any output.

## Structure
- `value_t` comes from the `isa` package, unchanged.
- Add `scanner_state_t` (IDLE, STREAM) to `isa` so that the top-level controller and the bench can share it.
- One sub-module, `raster_counter` (params W, H):
  - ports: `clk`, `rst`, `clear`, `advance`, `x`, `y`, `eol`, `last`;
  - it holds the x/y wrap logic and flag decode.
- `video_scanner` holds the FSM, the snapshot array, the output mux and the dropped-request logic.

## Test plan
All scenarios use W=4, H=3, with core (x,y) driving `video_in` = 16*y + x.
- Reset, then idle with `frame_req`=0 for 10 cycles -> `pixel_valid`=0, `busy`=0, `frame_dropped`=0 throughout.
- One-cycle `frame_req` pulse at edge N, `pixel_ready`=1 -> valid from cycle N+1 for exactly 12 cycles; data 0,1,2,3,16,…,35; `sof` on the first pixel only; `eol` on pixels 4, 8, 12; `last` on pixel 12; then `busy`=0.
- Capture, then change every `video_in` to 0xFF the cycle after -> the streamed frame is still 0..35.
- Random `pixel_ready` (50% duty) -> the sequence is identical to the previous scenario, and data, coordinates and flags are stable whenever valid && !ready.
- `frame_req` held high for 40 cycles with ready=1:
  - back-to-back frames with exactly one idle cycle between them;
  - `frame_dropped` pulses on every STREAM cycle after the first;
  - no recapture mid-frame.
- Assert `rst` while streaming pixel (2,1) -> `pixel_valid`=0 the next cycle; a new `frame_req` restarts from (0,0) with a fresh snapshot.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared data types for the core grid and the frame readout path.
// value_t is the per-core video word; scanner_state_t is the readout controller state.
package isa;

    typedef logic [7:0] value_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } scanner_state_t;

    // Counter width for n positions, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster x/y position counter with row/frame-end decode; zero latency decode.
// Advances only when advance=1, so the owner holds position under backpressure.
module raster_counter import isa::*; #(
    parameter int W = 8,
    parameter int H = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    advance,
    output logic [cnt_width(W)-1:0] x,
    output logic [cnt_width(H)-1:0] y,
    output logic                    eol,
    output logic                    last
);
    localparam int XW = cnt_width(W);
    localparam int YW = cnt_width(H);
    localparam logic [XW-1:0] X_MAX = XW'(W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(H - 1);

    assign eol  = (x == X_MAX);
    assign last = eol && (y == Y_MAX);

    // Wrapping on the last pixel leaves the counter at (0,0) ready for the next frame.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (eol) begin
                x <= '0;
                y <= last ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/video_scanner.sv
// Snapshots the W*H video grid on frame_req, then streams it in raster order.
// First pixel one cycle after capture; pixel_ready=0 holds every output stable.
module video_scanner import isa::*; #(
    parameter int W = 8,
    parameter int H = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  value_t                  video_in [W*H],
    input  logic                    frame_req,
    input  logic                    pixel_ready,
    output logic                    pixel_valid,
    output value_t                  pixel_data,
    output logic [cnt_width(W)-1:0] pixel_x,
    output logic [cnt_width(H)-1:0] pixel_y,
    output logic                    pixel_sof,
    output logic                    pixel_eol,
    output logic                    pixel_last,
    output logic                    busy,
    output logic                    frame_dropped
);
    localparam int N  = W * H;
    localparam int IW = cnt_width(N);

    scanner_state_t state, state_nxt;
    value_t         snap [N];
    logic           capture;
    logic           advance;
    logic [IW-1:0]  idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (frame_req) begin
                    capture   = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                advance = pixel_ready;
                if (pixel_ready && pixel_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The snapshot only loads from IDLE, so the cores may keep updating while the frame drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap <= '{default: '0};
        end else if (capture) begin
            snap <= video_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_dropped <= 1'b0;
        end else begin
            frame_dropped <= (state == STREAM) && frame_req;
        end
    end

    raster_counter #(
        .W(W),
        .H(H)
    ) u_raster (
        .clk    (clk),
        .rst    (rst),
        .clear  (capture),
        .advance(advance),
        .x      (pixel_x),
        .y      (pixel_y),
        .eol    (pixel_eol),
        .last   (pixel_last)
    );

    assign idx         = IW'(pixel_y) * IW'(W) + IW'(pixel_x);
    assign pixel_data  = snap[idx];
    assign pixel_sof   = (pixel_x == '0) && (pixel_y == '0);
    assign pixel_valid = (state == STREAM);
    assign busy        = (state == STREAM);

endmodule

// File: tb/tb_video_scanner.sv
// Randomised and directed bench for video_scanner (4x3 grid plus a 1x1 corner case).
// A frame-level reference model predicts every output on every sampled cycle.
module tb_video_scanner;
    import isa::*;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst;
    value_t     video_in [N];
    logic       frame_req;
    logic       pixel_ready;
    logic       pixel_valid;
    value_t     pixel_data;
    logic [1:0] pixel_x;
    logic [1:0] pixel_y;
    logic       pixel_sof, pixel_eol, pixel_last, busy, frame_dropped;

    value_t     video1 [1];
    logic       req1, rdy1;
    logic       valid1, sof1, eol1, last1, busy1, dropped1;
    value_t     data1;
    logic [0:0] x1, y1;

    int errors = 0;
    int checks = 0;

    scanner_state_t m_state;
    int             m_k;
    value_t         m_snap [N];
    logic           m_dropped;

    always #5 clk = ~clk;

    video_scanner #(.W(W), .H(H)) dut (
        .clk(clk), .rst(rst), .video_in(video_in), .frame_req(frame_req),
        .pixel_ready(pixel_ready), .pixel_valid(pixel_valid), .pixel_data(pixel_data),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_sof(pixel_sof), .pixel_eol(pixel_eol),
        .pixel_last(pixel_last), .busy(busy), .frame_dropped(frame_dropped)
    );

    video_scanner #(.W(1), .H(1)) dut1 (
        .clk(clk), .rst(rst), .video_in(video1), .frame_req(req1),
        .pixel_ready(rdy1), .pixel_valid(valid1), .pixel_data(data1),
        .pixel_x(x1), .pixel_y(y1), .pixel_sof(sof1), .pixel_eol(eol1),
        .pixel_last(last1), .busy(busy1), .frame_dropped(dropped1)
    );

    // Model advances with the inputs as they will be sampled at the coming edge.
    task automatic tick();
        if (rst) begin
            m_state   = IDLE;
            m_k       = 0;
            m_dropped = 1'b0;
            for (int i = 0; i < N; i++) m_snap[i] = '0;
        end else begin
            m_dropped = (m_state == STREAM) && frame_req;
            if (m_state == IDLE) begin
                if (frame_req) begin
                    for (int i = 0; i < N; i++) m_snap[i] = video_in[i];
                    m_k     = 0;
                    m_state = STREAM;
                end
            end else if (pixel_ready) begin
                if (m_k == N - 1) begin
                    m_state = IDLE;
                    m_k     = 0;
                end else begin
                    m_k++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] exp_vec();
        logic v;
        v = (m_state == STREAM);
        return {v, v, m_snap[m_k], 2'(m_k % W), 2'(m_k / W),
                (m_k == 0), ((m_k % W) == W - 1), (m_k == N - 1), m_dropped};
    endfunction

    function automatic logic [17:0] obs_vec();
        return {pixel_valid, busy, pixel_data, pixel_x, pixel_y,
                pixel_sof, pixel_eol, pixel_last, frame_dropped};
    endfunction

    task automatic set_pattern(input int offset);
        for (int i = 0; i < N; i++) video_in[i] = value_t'(16 * (i / W) + (i % W) + offset);
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_req = 1'b0; pixel_ready = 1'b0; req1 = 1'b0; rdy1 = 1'b1;
        video1[0] = 8'h00;
        set_pattern(0);
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({pixel_valid, busy, frame_dropped, pixel_sof, pixel_data} !== {4'b0001, 8'h00}) begin
            errors++;
            $display("FAIL reset_state got v/b/d/sof/data=%b%b%b%b/%h want 0001/00",
                     pixel_valid, busy, frame_dropped, pixel_sof, pixel_data);
        end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (obs_vec() !== exp_vec() || pixel_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_single_frame();
        value_t q[$];
        int nvalid = 0;
        pixel_ready = 1'b1;
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        for (int c = 0; c < 16; c++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single_frame cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            if (pixel_valid) begin
                nvalid++;
                q.push_back(pixel_data);
            end
            tick();
        end
        checks++;
        if (nvalid != N) begin
            errors++;
            $display("FAIL single_frame_len got=%0d want=%0d", nvalid, N);
        end
        for (int i = 0; i < q.size(); i++) begin
            checks++;
            if (q[i] !== value_t'(16 * (i / W) + (i % W))) begin
                errors++;
                $display("FAIL single_frame_data idx=%0d got=%h want=%h", i, q[i], 16 * (i / W) + (i % W));
            end
        end
    endtask

    task automatic test_freeze();
        value_t q[$];
        pixel_ready = 1'b1;
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        for (int i = 0; i < N; i++) video_in[i] = 8'hFF;
        for (int c = 0; c < 14; c++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL freeze cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            if (pixel_valid) q.push_back(pixel_data);
            tick();
        end
        checks++;
        if (q.size() != N) begin
            errors++;
            $display("FAIL freeze_len got=%0d want=%0d", q.size(), N);
        end
        for (int i = 0; i < q.size(); i++) begin
            checks++;
            if (q[i] !== value_t'(16 * (i / W) + (i % W))) begin
                errors++;
                $display("FAIL freeze_data idx=%0d got=%h want=%h", i, q[i], 16 * (i / W) + (i % W));
            end
        end
        set_pattern(0);
    endtask

    task automatic test_random_ready();
        value_t q[$];
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        for (int c = 0; c < 300 && q.size() < N; c++) begin
            pixel_ready = 1'($urandom_range(0, 1));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_ready cyc=%0d rdy=%b got=%h want=%h", c, pixel_ready, obs_vec(), exp_vec());
            end
            if (pixel_valid && pixel_ready) q.push_back(pixel_data);
            tick();
        end
        checks++;
        if (q.size() != N) begin
            errors++;
            $display("FAIL random_ready_len got=%0d want=%0d", q.size(), N);
        end
        for (int i = 0; i < q.size(); i++) begin
            checks++;
            if (q[i] !== value_t'(16 * (i / W) + (i % W))) begin
                errors++;
                $display("FAIL random_ready_data idx=%0d got=%h want=%h", i, q[i], 16 * (i / W) + (i % W));
            end
        end
        pixel_ready = 1'b1;
        checks++;
        if (obs_vec() !== exp_vec() || pixel_valid !== 1'b0) begin
            errors++;
            $display("FAIL random_ready_end got=%h want=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        int  gap = 0, starts = 0, drops = 0;
        bit  seen = 0;
        logic prev = 1'b0;
        pixel_ready = 1'b1;
        frame_req = 1'b1;
        for (int c = 0; c < 40; c++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            if (frame_dropped) drops++;
            if (pixel_valid && !prev) begin
                starts++;
                if (seen) begin
                    checks++;
                    if (gap != 1) begin
                        errors++;
                        $display("FAIL back_to_back_gap got=%0d want=1", gap);
                    end
                end
                seen = 1;
                gap  = 0;
            end else if (!pixel_valid) begin
                gap++;
            end
            prev = pixel_valid;
            tick();
        end
        checks++;
        if (starts != 3) begin
            errors++;
            $display("FAIL back_to_back_frames got=%0d want=3", starts);
        end
        // Three frames, each with 11 later STREAM cycles plus the trailing bubble flagged.
        checks++;
        if (drops != 36) begin
            errors++;
            $display("FAIL back_to_back_drops got=%0d want=36", drops);
        end
        frame_req = 1'b0;
        for (int c = 0; c < 14; c++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_drain cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        pixel_ready = 1'b1;
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        checks++;
        if ({pixel_valid, pixel_x, pixel_y} !== 5'b1_10_01 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_mid_pos got v/x/y=%b/%0d/%0d want 1/2/1", pixel_valid, pixel_x, pixel_y);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (pixel_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_mid_abort got=%h want=%h", obs_vec(), exp_vec());
        end
        set_pattern(100);
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        checks++;
        if ({pixel_valid, pixel_x, pixel_y, pixel_sof, pixel_data} !== {1'b1, 4'b0000, 1'b1, 8'd100}) begin
            errors++;
            $display("FAIL reset_mid_restart got v/x/y/sof/data=%b/%0d/%0d/%b/%0d want 1/0/0/1/100",
                     pixel_valid, pixel_x, pixel_y, pixel_sof, pixel_data);
        end
        for (int c = 0; c < 14; c++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid_frame cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_single_pixel();
        video1[0] = 8'h5A;
        rdy1 = 1'b1;
        req1 = 1'b1;
        tick();
        req1 = 1'b0;
        checks++;
        if ({valid1, busy1, sof1, eol1, last1, data1, x1, y1} !== {5'b11111, 8'h5A, 2'b00}) begin
            errors++;
            $display("FAIL one_pixel got v/b/sof/eol/last/data=%b%b%b%b%b/%h want 11111/5a",
                     valid1, busy1, sof1, eol1, last1, data1);
        end
        tick();
        checks++;
        if ({valid1, busy1, dropped1} !== 3'b000) begin
            errors++;
            $display("FAIL one_pixel_end got v/b/d=%b%b%b want 000", valid1, busy1, dropped1);
        end
        req1 = 1'b1;
        tick();
        video1[0] = 8'h33;
        tick();
        checks++;
        if ({valid1, dropped1} !== 2'b01) begin
            errors++;
            $display("FAIL one_pixel_held_drop got v/d=%b%b want 01", valid1, dropped1);
        end
        tick();
        req1 = 1'b0;
        checks++;
        if ({valid1, dropped1, data1} !== {2'b10, 8'h33}) begin
            errors++;
            $display("FAIL one_pixel_recapture got v/d/data=%b%b/%h want 10/33", valid1, dropped1, data1);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_freeze();
        test_random_ready();
        test_back_to_back();
        test_reset_mid();
        test_single_pixel();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
